// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: in-order imem fetch into a BUF_DEPTH-entry instruction queue; response to instr_valid is 1 cycle.
// Backpressure: stall holds the head, credits throttle requests; FETCH_MISALIGN_CHECK_EN adds misalign_err and HALT.
module instr_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(BUF_DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] { RUN, FLUSH, HALT } state_t;
`else
  typedef enum logic { RUN, FLUSH } state_t;
`endif

  state_t state, state_nxt;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  aq_addr [BUF_DEPTH];
  logic [PTR_W-1:0] aq_wr, aq_rd;
  logic [CNT_W-1:0] inflight, inflight_nxt, drop_cnt;

  logic [XLEN-1:0]  iq_pc   [BUF_DEPTH];
  logic [XLEN-1:0]  iq_word [BUF_DEPTH];
  logic [PTR_W-1:0] iq_wr, iq_rd;
  logic [CNT_W-1:0] iq_cnt;

  logic            credit, req_fire, resp_take, resp_keep, pop, pc_load;
  logic [XLEN-1:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  // Every outstanding request owns a future queue slot, so issue is gated on both.
  assign credit         = ({1'b0, inflight} + {1'b0, iq_cnt}) < DEPTH_C;
  assign imem_req_valid = rst_n & (state == RUN) & credit & ~redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign resp_take    = imem_resp_valid & (inflight != '0);
  assign resp_keep    = resp_take & (state == RUN) & ~redirect_valid;
  assign inflight_nxt = inflight + CNT_W'(req_fire) - CNT_W'(resp_take);

  assign instr_valid = rst_n & (iq_cnt != '0);
  assign pop         = instr_valid & ~stall;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic bad_redirect;
  assign bad_redirect = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign pc_load      = redirect_valid & (state != HALT);
  assign misalign_err = (state == HALT);
`else
  assign pc_load      = redirect_valid;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (redirect_valid) state_nxt = (inflight_nxt != '0) ? FLUSH : RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (bad_redirect) state_nxt = HALT;
`endif
      end
      FLUSH: begin
        if (drop_cnt == '0 || (resp_take && drop_cnt == CNT_W'(1))) state_nxt = RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (bad_redirect) state_nxt = HALT;
`endif
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      aq_wr    <= '0;
      aq_rd    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      iq_wr    <= '0;
      iq_rd    <= '0;
      iq_cnt   <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (req_fire) begin
        aq_wr    <= aq_wr + 1'b1;
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (resp_take) aq_rd <= aq_rd + 1'b1;
      if (pc_load) fetch_pc <= redirect_aligned;

      // A redirect orphans everything still in flight; those responses are counted off in FLUSH.
      if (redirect_valid) begin
        drop_cnt <= inflight_nxt;
        iq_wr    <= '0;
        iq_rd    <= '0;
        iq_cnt   <= '0;
      end else begin
        if (state == FLUSH && resp_take) drop_cnt <= drop_cnt - CNT_W'(1);
        if (resp_keep) iq_wr <= iq_wr + 1'b1;
        if (pop)       iq_rd <= iq_rd + 1'b1;
        case ({resp_keep, pop})
          2'b10:   iq_cnt <= iq_cnt + CNT_W'(1);
          2'b01:   iq_cnt <= iq_cnt - CNT_W'(1);
          default: iq_cnt <= iq_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) aq_addr[aq_wr] <= fetch_pc;
    if (resp_keep) begin
      iq_pc[iq_wr]   <= aq_addr[aq_rd];
      iq_word[iq_wr] <= imem_resp_data;
    end
  end

  assign instr          = iq_word[iq_rd];
  assign instr_pc       = iq_pc[iq_rd];
  assign instr_pc_plus4 = instr_pc + XLEN'(4);
  assign op             = instr[6:0];
  assign funct3         = instr[14:12];
  assign funct7         = instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: variable-latency memory environment plus a queue-level fetch model.
module tb_instr_fetch_unit;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_data;
  logic        redirect_valid, stall, instr_valid;
  logic [31:0] redirect_pc, instr, instr_pc, instr_pc_plus4;
  logic [6:0]  op, funct7;
  logic [2:0]  funct3;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int checks = 0, failures = 0, cyc = 0;

  logic [31:0] mem_q[$];
  int          mem_due[$];
  int          last_due = 0, lat_lo = 1, lat_hi = 1;

  logic [31:0] m_pc;
  logic [31:0] m_inf[$];
  logic [63:0] m_iq[$];
  int          m_drop;
  bit          m_halt;

  logic         o_req, o_ivld, o_merr;
  logic [31:0]  o_addr, o_ipc, o_instr;
  logic [6:0]   o_op;
  logic [147:0] obs, exp_v;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
    .op(op), .funct3(funct3), .funct7(funct7)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00B5_0533;
  endfunction

  function automatic bit mem_due_now();
    return mem_q.size() > 0 && mem_due[0] <= cyc;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    m_inf.delete();
    m_iq.delete();
    m_drop = 0;
    m_halt = 0;
  endtask

  // One clock: drive inputs, sample outputs, form model expectation, advance memory and model.
  task automatic step(input bit rst, input bit rdy, input bit stl, input bit rdr, input logic [31:0] rpc);
    logic        e_req, e_ivld, take;
    logic [63:0] head;
    logic [31:0] a;
    int          due;
    a = 32'h0;
    rst_n = !rst;
    imem_req_ready = rdy;
    stall = stl;
    redirect_valid = rdr;
    redirect_pc = rpc;
    if (mem_due_now()) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word_of(mem_q[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    #2;
    o_req = imem_req_valid;  o_addr = imem_req_addr;
    o_ivld = instr_valid;    o_ipc = instr_pc;  o_instr = instr;  o_op = op;
`ifdef FETCH_MISALIGN_CHECK_EN
    o_merr = misalign_err;
`else
    o_merr = 1'b0;
`endif
    obs = {o_req, o_req ? o_addr : 32'h0, o_ivld,
           o_ivld ? {instr, instr_pc, instr_pc_plus4, op, funct3, funct7} : 113'h0, o_merr};

    e_req  = !rst && !m_halt && m_drop == 0 && (m_inf.size() + m_iq.size() < DEPTH) && !rdr;
    e_ivld = !rst && m_iq.size() > 0;
    head   = e_ivld ? m_iq[0] : 64'h0;
    exp_v  = {e_req, e_req ? m_pc : 32'h0, e_ivld,
              e_ivld ? {head[31:0], head[63:32], head[63:32] + 32'd4, head[6:0], head[14:12], head[31:25]} : 113'h0,
              m_halt};

    if (imem_req_valid && imem_req_ready) begin
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      mem_q.push_back(imem_req_addr);
      mem_due.push_back(due);
      last_due = due;
    end
    if (imem_resp_valid) begin
      void'(mem_q.pop_front());
      void'(mem_due.pop_front());
    end

    take = imem_resp_valid && m_inf.size() > 0;
    if (rst) model_reset();
    else begin
      if (take) a = m_inf.pop_front();
      if (rdr) begin
        m_iq.delete();
        if (!m_halt) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (rpc[1:0] != 2'b00) m_halt = 1; else
`endif
          m_pc = rpc & 32'hFFFF_FFFC;
        end
        m_drop = m_inf.size();
      end else begin
        if (m_iq.size() > 0 && !stl) void'(m_iq.pop_front());
        if (take) begin
          if (m_drop > 0) m_drop--;
          else if (!m_halt) m_iq.push_back({a, imem_resp_data});
        end
        if (e_req && rdy) begin
          m_inf.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, 0, 32'h0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL reset_vec cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    end
    step(0, 0, 0, 0, 32'h0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL reset_release_vec got=%h exp=%h", obs, exp_v); end
    checks++;
    if ({o_req, o_addr, o_ivld} !== {1'b1, RST_PC, 1'b0}) begin
      failures++; $display("FAIL reset_first_req got req=%b addr=%h ivld=%b exp req=1 addr=%h ivld=0", o_req, o_addr, o_ivld, RST_PC);
    end
  endtask

  task automatic test_basic();
    lat_lo = 1; lat_hi = 1;
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 0, 0, 32'h0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL basic_vec k=%0d got=%h exp=%h", k, obs, exp_v); end
      if (k == 2) begin
        checks++;
        if ({o_ivld, o_ipc, o_instr, o_op} !== {1'b1, 32'h0, 32'h00B5_0533, 7'b0110011}) begin
          failures++; $display("FAIL basic_first_instr got ivld=%b pc=%h instr=%h op=%b exp 1/0/00b50533/0110011", o_ivld, o_ipc, o_instr, o_op);
        end
      end
    end
  endtask

  task automatic test_stall();
    lat_lo = 1; lat_hi = 1;
    step(1, 0, 0, 0, 32'h0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL stall_reset_vec got=%h exp=%h", obs, exp_v); end
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 1, 0, 32'h0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL stall_vec k=%0d got=%h exp=%h", k, obs, exp_v); end
      if (k >= 2) begin
        checks++;
        if ({o_ivld, o_ipc, o_instr} !== {1'b1, 32'h0, word_of(32'h0)}) begin
          failures++; $display("FAIL stall_head_hold k=%0d got ivld=%b pc=%h instr=%h exp pc=0", k, o_ivld, o_ipc, o_instr);
        end
      end
    end
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 0, 0, 32'h0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL stall_release_vec k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  task automatic test_redirect_flush();
    bit          seen_req, seen_instr;
    logic [31:0] first_addr;
    lat_lo = 3; lat_hi = 3;
    seen_req = 0; seen_instr = 0; first_addr = 32'h0;
    for (int i = 0; i < 40 && m_inf.size() != 2; i++) begin
      step(0, 1, 0, 0, 32'h0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL flush_fill_vec got=%h exp=%h", obs, exp_v); end
    end
    step(0, 1, 0, 1, 32'h0000_0100);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL flush_redirect_vec got=%h exp=%h", obs, exp_v); end
    step(0, 1, 0, 0, 32'h0);
    checks++;
    if (o_req !== 1'b0) begin failures++; $display("FAIL flush_no_req got req=%b exp 0", o_req); end
    for (int i = 0; i < 40 && !seen_instr; i++) begin
      step(0, 1, 0, 0, 32'h0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL flush_resume_vec got=%h exp=%h", obs, exp_v); end
      if (o_req && !seen_req) begin seen_req = 1; first_addr = o_addr; end
      if (o_ivld) seen_instr = 1;
    end
    checks++;
    if ({seen_instr, o_ipc, first_addr} !== {1'b1, 32'h100, 32'h100}) begin
      failures++; $display("FAIL flush_target got seen=%b pc=%h first_req=%h exp pc=100 req=100", seen_instr, o_ipc, first_addr);
    end
  endtask

  task automatic test_redirect_resp_stall();
    bit found, seen;
    lat_lo = 1; lat_hi = 1;
    found = 0; seen = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_due_now() && m_iq.size() > 0 && m_inf.size() > 0) found = 1;
      else begin
        step(0, 1, 0, 0, 32'h0);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL rrs_setup_vec got=%h exp=%h", obs, exp_v); end
      end
    end
    step(0, 1, 1, 1, 32'h0000_0200);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL rrs_redirect_vec got=%h exp=%h", obs, exp_v); end
    step(0, 1, 1, 0, 32'h0);
    checks++;
    if ({found, o_ivld} !== 2'b10) begin failures++; $display("FAIL rrs_cleared got setup=%b ivld=%b exp setup=1 ivld=0", found, o_ivld); end
    for (int i = 0; i < 40 && !seen; i++) begin
      step(0, 1, 0, 0, 32'h0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL rrs_resume_vec got=%h exp=%h", obs, exp_v); end
      if (o_ivld) seen = 1;
    end
    checks++;
    if ({seen, o_ipc} !== {1'b1, 32'h200}) begin failures++; $display("FAIL rrs_target got seen=%b pc=%h exp pc=200", seen, o_ipc); end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (m_inf.size() > 0 || mem_q.size() > 0 || m_iq.size() > 0); i++) begin
      step(0, 0, 0, 0, 32'h0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL drain_vec got=%h exp=%h", obs, exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    lat_lo = 2; lat_hi = 2;
    seen = 0;
    drain();
    step(0, 1, 0, 0, 32'h0);
    checks++;
    if (o_req !== 1'b1) begin failures++; $display("FAIL rmid_issue got req=%b exp 1", o_req); end
    step(1, 0, 0, 0, 32'h0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL rmid_reset_vec got=%h exp=%h", obs, exp_v); end
    step(0, 0, 0, 0, 32'h0);
    checks++;
    if ({o_req, o_addr, obs} !== {1'b1, RST_PC, exp_v}) begin
      failures++; $display("FAIL rmid_restart got req=%b addr=%h vec=%h exp addr=%h vec=%h", o_req, o_addr, obs, RST_PC, exp_v);
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      step(0, 1, 0, 0, 32'h0);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL rmid_vec got=%h exp=%h", obs, exp_v); end
      if (o_ivld) seen = 1;
    end
    checks++;
    if ({seen, o_ipc, o_instr} !== {1'b1, RST_PC, word_of(RST_PC)}) begin
      failures++; $display("FAIL rmid_first_instr got seen=%b pc=%h instr=%h exp pc=%h instr=%h", seen, o_ipc, o_instr, RST_PC, word_of(RST_PC));
    end
  endtask

  task automatic test_misalign();
    lat_lo = 1; lat_hi = 2;
    drain();
    step(0, 0, 0, 1, 32'h0000_0102);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL mis_redirect_vec got=%h exp=%h", obs, exp_v); end
    step(0, 1, 0, 0, 32'h0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL mis_next_vec got=%h exp=%h", obs, exp_v); end
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, 32'h0);
      checks++;
      if ({o_merr, o_req} !== 2'b10) begin failures++; $display("FAIL mis_halt i=%0d got err=%b req=%b exp err=1 req=0", i, o_merr, o_req); end
    end
    step(1, 1, 0, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0);
    checks++;
    if ({o_merr, o_req, o_addr} !== {2'b01, RST_PC}) begin
      failures++; $display("FAIL mis_reset_clear got err=%b req=%b addr=%h exp err=0 req=1 addr=%h", o_merr, o_req, o_addr, RST_PC);
    end
`else
    checks++;
    if ({o_req, o_addr} !== {1'b1, 32'h100}) begin failures++; $display("FAIL mis_mask got req=%b addr=%h exp req=1 addr=100", o_req, o_addr); end
`endif
  endtask

  task automatic test_random();
    bit          rst, rdy, stl, rdr;
    logic [31:0] rpc;
    lat_lo = 1; lat_hi = 4;
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(199) == 0);
      rdy = ($urandom_range(99) < 75);
      stl = ($urandom_range(99) < 30);
      rdr = ($urandom_range(99) < 5);
      rpc = $urandom & 32'h0000_FFFF;
`ifdef FETCH_MISALIGN_CHECK_EN
      rpc[1:0] = 2'b00;
`endif
      step(rst, rdy, stl, rdr, rpc);
      checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL random_vec k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  initial begin
    rst_n = 0; imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 32'h0;
    redirect_valid = 0; redirect_pc = 32'h0; stall = 0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_flush();
    test_redirect_resp_stall();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
